bias_relu: RTL and testbench
============================

BIAS_RELU -- requirements
Module: bias_relu

Interface
REQ-001 Parameters (name, default, meaning): NUM_INPUTS, 8, lane count (outputs == inputs).
REQ-002 DATA_WIDTH, 8, per-lane signed two's-complement width; input and output widths are equal.
REQ-003 LOG_MAX_ITEMS, 16, width of the item-count configuration field.
REQ-004 Ports (name, direction, width, meaning): clk, input, 1, single clock; all logic on rising edge.
REQ-005 rst, input, 1, asynchronous active-low reset.
REQ-006 configure, input, 1, CONFIGURE interface: load-configuration strobe.
REQ-007 num_items, input, LOG_MAX_ITEMS, CONFIGURE interface: number of input words to process.
REQ-008 bias_in, input, NUM_INPUTS*DATA_WIDTH, CONFIGURE interface: per-lane bias; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 relu_en, input, 1, CONFIGURE interface: enable ReLU.
REQ-010 data_in, input, NUM_INPUTS*DATA_WIDTH, IN interface: data from the accumulator stage.
REQ-011 valid_in, input, 1, IN interface: data_in is valid.
REQ-012 avail_out, output, 1, IN interface: block accepts a word this cycle.
REQ-013 data_out, output, NUM_INPUTS*DATA_WIDTH, OUT interface: data.
REQ-014 valid_out, output, 1, OUT interface: data_out is valid.
REQ-015 avail_in, input, 1, OUT interface: downstream accepts a word this cycle.
REQ-016 done, output, 1, one-cycle pulse when the last configured item leaves on OUT.

Function
REQ-017 Input transfer: valid_in && avail_out in the same cycle; output transfer: valid_out && avail_in in the same cycle.
REQ-018 State machine: IDLE, RUN, DONE; reset enters IDLE.
- IDLE: configure=1 latches num_items, bias_in and relu_en, clears both counters, then goes to RUN, or to DONE when num_items=0.
- RUN: goes to DONE in the cycle after the output transfer that brings out_cnt to num_items.
- DONE: done=1 for exactly one cycle, then unconditionally back to IDLE.
REQ-019 configure is ignored in RUN and DONE; latched configuration stays unchanged.
REQ-020 avail_out = 1 only in RUN, with in_cnt < num_items, and stage 1 empty or advancing this cycle; otherwise 0.
REQ-021 Two-stage pipeline.
- Stage 1 registers per-lane saturated sum(data_in, bias).
- Stage 2 registers the optional ReLU result and drives data_out and valid_out.
REQ-022 Stage 2 empties on an output transfer; stage 1 advances when stage 2 is empty or emptying this cycle.
REQ-023 Latency: with avail_in held at 1, a word accepted in cycle N appears with valid_out=1 in cycle N+2; throughput is one word per cycle.
REQ-024 Back-pressure: with avail_in=0, data_out and valid_out hold stable; no word is dropped or duplicated; at most 2 words are in flight.
REQ-025 Arithmetic: per-lane sum is computed at DATA_WIDTH+1 bits signed, then clipped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-026 ReLU: with relu_en=1, a negative clipped value becomes 0; with relu_en=0, the clipped value passes unchanged.
REQ-027 Lanes are independent; no carry or saturation crosses lanes.
REQ-028 in_cnt increments on each input transfer; out_cnt increments on each output transfer; both saturate at num_items.
REQ-029 A simultaneous input and output transfer in the same cycle advances both counters and the pipeline correctly.
REQ-030 valid_in while avail_out=0 (IDLE, DONE, in_cnt=num_items, or stall) is not consumed; the upstream holds the word.

Reset
REQ-031 rst=0 asynchronously forces the following, regardless of clk:
- IDLE state; in_cnt=0, out_cnt=0.
- Stage 1 and stage 2 valid bits = 0.
- avail_out=0, valid_out=0, done=0, data_out=0.
- Latched configuration = 0.
REQ-032 Reset asserted mid-RUN discards all in-flight words; after release the block waits in IDLE for configure.
REQ-033 Reset release is synchronised internally; no output changes before the first rising clk edge after release.

Verification
REQ-034 Basic: DATA_WIDTH=8, num_items=3, bias lane0=5, relu_en=0, inputs 10,20,30 on lane0, avail_in=1 -> lane0 outputs 15,25,35 at cycles N+2, N+3, N+4; done pulses one cycle after the third output.
REQ-035 Saturation: bias=100, input 100 -> 127; bias=-100, input -100 -> -128 with relu_en=0, and 0 with relu_en=1.
REQ-036 Back-pressure: num_items=4, avail_in=0 for 5 cycles after the first output -> avail_out drops after 2 words are in flight, data_out is stable, and 4 words arrive in order once avail_in=1.
REQ-037 Zero items: configure with num_items=0 -> done pulses in the next cycle; avail_out stays 0; valid_out stays 0.
REQ-038 Mid-run reset: rst=0 after 2 of 5 words accepted -> all outputs at reset values immediately; configure after release starts a fresh run with correct results.
REQ-039 Ignored reconfigure: configure in RUN with a different bias -> results keep using the original bias until done.

Source files
------------

// File: rtl/bias_relu.sv
// bias_relu: per-lane saturating bias add followed by optional ReLU.
//
// Two-stage valid/avail pipeline that processes a configured number of words.
//   clk        - rising-edge clock
//   rst        - asynchronous active-low reset (release synchronised internally)
//   configure  - load num_items/bias_in/relu_en while idle
//   num_items  - number of words to process in this run
//   bias_in    - per-lane signed bias, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   relu_en    - clamp negative results to zero
//   data_in    - input word, valid_in qualifies it, avail_out accepts it
//   data_out   - output word, valid_out qualifies it, avail_in accepts it
//   done       - one-cycle pulse after the last configured word leaves
module bias_relu #(
  parameter int unsigned NUM_INPUTS    = 8,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned LOG_MAX_ITEMS = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             configure,
  input  logic [LOG_MAX_ITEMS-1:0]         num_items,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] bias_in,
  input  logic                             relu_en,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
  input  logic                             valid_in,
  output logic                             avail_out,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] data_out,
  output logic                             valid_out,
  input  logic                             avail_in,
  output logic                             done
);

  localparam int unsigned VW = NUM_INPUTS * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, state_next;
  logic [1:0]               rst_sync;
  logic                     rst_n;
  logic [LOG_MAX_ITEMS-1:0] cfg_num;
  logic [VW-1:0]            cfg_bias;
  logic                     cfg_relu;
  logic [LOG_MAX_ITEMS-1:0] in_cnt, out_cnt;
  logic                     s1_valid, s2_valid;
  logic [VW-1:0]            s1_data, s2_data;
  logic [VW-1:0]            s1_next, s2_next;
  logic                     in_xfer, out_xfer, s1_adv;

  logic signed [DATA_WIDTH-1:0] lane_a, lane_b, lane_r;
  logic signed [DATA_WIDTH:0]   lane_sum;

  // Assertion is immediate; release reaches the core two edges later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign out_xfer  = s2_valid && avail_in;
  assign s1_adv    = !s2_valid || out_xfer;
  assign avail_out = (state == RUN) && (in_cnt < cfg_num) && (!s1_valid || s1_adv);
  assign in_xfer   = valid_in && avail_out;
  assign data_out  = s2_data;
  assign valid_out = s2_valid;
  assign done      = (state == DONE);

  // Stage-1 arithmetic: one guard bit detects overflow per lane.
  always_comb begin
    s1_next  = '0;
    lane_a   = '0;
    lane_b   = '0;
    lane_sum = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      lane_a   = data_in[i*DATA_WIDTH +: DATA_WIDTH];
      lane_b   = cfg_bias[i*DATA_WIDTH +: DATA_WIDTH];
      lane_sum = {lane_a[DATA_WIDTH-1], lane_a} + {lane_b[DATA_WIDTH-1], lane_b};
      if (lane_sum[DATA_WIDTH] != lane_sum[DATA_WIDTH-1])
        s1_next[i*DATA_WIDTH +: DATA_WIDTH] = lane_sum[DATA_WIDTH]
          ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else
        s1_next[i*DATA_WIDTH +: DATA_WIDTH] = lane_sum[DATA_WIDTH-1:0];
    end
  end

  // Stage-2 ReLU.
  always_comb begin
    s2_next = '0;
    lane_r  = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      lane_r = s1_data[i*DATA_WIDTH +: DATA_WIDTH];
      s2_next[i*DATA_WIDTH +: DATA_WIDTH] = (cfg_relu && lane_r[DATA_WIDTH-1]) ? '0 : lane_r;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (configure) state_next = (num_items == '0) ? DONE : RUN;
      RUN:  if (out_xfer && (out_cnt == cfg_num - LOG_MAX_ITEMS'(1))) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_num  <= '0;
      cfg_bias <= '0;
      cfg_relu <= 1'b0;
      in_cnt   <= '0;
      out_cnt  <= '0;
    end else if (state == IDLE && configure) begin
      cfg_num  <= num_items;
      cfg_bias <= bias_in;
      cfg_relu <= relu_en;
      in_cnt   <= '0;
      out_cnt  <= '0;
    end else begin
      if (in_xfer) in_cnt <= in_cnt + LOG_MAX_ITEMS'(1);
      if (out_xfer && out_cnt < cfg_num) out_cnt <= out_cnt + LOG_MAX_ITEMS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid <= 1'b1;
        s1_data  <= s1_next;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s2_next;
      end
    end
  end

endmodule

// File: tb/tb_bias_relu.sv
module tb_bias_relu;

  localparam int unsigned NI = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned LM = 16;
  localparam int unsigned VW = NI * DW;

  typedef struct {
    logic [VW-1:0] d;
    int            acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          configure = 1'b0;
  logic [LM-1:0] num_items = '0;
  logic [VW-1:0] bias_in = '0;
  logic          relu_en = 1'b0;
  logic [VW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic          avail_out;
  logic [VW-1:0] data_out;
  logic          valid_out;
  logic          avail_in = 1'b1;
  logic          done;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            last_out_cyc = 0;
  bit            chk_lat = 1'b1;
  bit            prev_hold = 1'b0;
  logic [VW-1:0] prev_data = '0;

  bias_relu #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .LOG_MAX_ITEMS(LM)) dut (
    .clk(clk), .rst(rst), .configure(configure), .num_items(num_items),
    .bias_in(bias_in), .relu_en(relu_en), .data_in(data_in), .valid_in(valid_in),
    .avail_out(avail_out), .data_out(data_out), .valid_out(valid_out),
    .avail_in(avail_in), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks holds.
  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", VW'(valid_out), VW'(1));
        check("hold_data", data_out, prev_data);
      end
      if (valid_out && avail_in) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_output: got %h expected none", data_out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", data_out, e.d);
          if (chk_lat) check("latency", VW'(cyc - e.acc), VW'(2));
        end
        last_out_cyc = cyc;
      end
      prev_hold = valid_out && !avail_in;
      prev_data = data_out;
    end
  end

  task automatic cfg(input logic [LM-1:0] n, input logic [VW-1:0] b, input logic r);
    configure = 1'b1; num_items = n; bias_in = b; relu_en = r;
    @(posedge clk); #1;
    configure = 1'b0;
  endtask

  // Presents one word and returns one cycle after it is accepted.
  task automatic send(input logic [VW-1:0] d, input logic [VW-1:0] e);
    exp_t it;
    data_in = d;
    valid_in = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (avail_out) begin
        it.d = e; it.acc = cyc;
        sb.push_back(it);
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    n_cmp++; n_err++;
    $display("FAIL send_timeout: got no accept expected accept of %h", d);
    valid_in = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check({name, "_done_seen"}, VW'(seen), VW'(1));
    if (seen) begin
      check({name, "_done_cycle"}, VW'(cyc), VW'(last_out_cyc + 1));
      check({name, "_sb_empty"}, VW'(sb.size()), VW'(0));
      @(negedge clk);
      check({name, "_done_pulse"}, VW'(done), VW'(0));
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sb.delete();
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_avail_out", VW'(avail_out), VW'(0));
    check("rst_valid_out", VW'(valid_out), VW'(0));
    check("rst_done", VW'(done), VW'(0));
    check("rst_data_out", data_out, '0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Basic: lane0 bias 5, lane1 bias 127, lane2 bias -128
    cfg(16'd3, 64'h0000_0000_0080_7F05, 1'b0);
    send(64'h0000_0000_00FF_010A, 64'h0000_0000_0080_7F0F);
    send(64'h0000_0000_0000_0014, 64'h0000_0000_0080_7F19);
    send(64'h0000_0000_1000_001E, 64'h0000_0000_1080_7F23);
    valid_in = 1'b0;
    wait_done("basic");

    // Saturation, ReLU off then on
    cfg(16'd1, 64'h0000_0000_019C_9C64, 1'b0);
    send(64'h0000_0000_0232_9C64, 64'h0000_0000_03CE_807F);
    valid_in = 1'b0;
    wait_done("sat_norelu");
    cfg(16'd1, 64'h0000_0000_019C_9C64, 1'b1);
    send(64'h0000_0000_0232_9C64, 64'h0000_0000_0300_007F);
    valid_in = 1'b0;
    wait_done("sat_relu");

    // Back-pressure: stall for 5 cycles after the first output
    chk_lat = 1'b0;
    cfg(16'd4, 64'h0000_0000_0000_0001, 1'b0);
    fork
      begin
        send(64'h0101_0101_0101_0101, 64'h0101_0101_0101_0102);
        send(64'h0202_0202_0202_0202, 64'h0202_0202_0202_0203);
        send(64'h0303_0303_0303_0303, 64'h0303_0303_0303_0304);
        send(64'h0404_0404_0404_0404, 64'h0404_0404_0404_0405);
        valid_in = 1'b0;
      end
      begin
        bit got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
          @(negedge clk);
          if (valid_out) got = 1'b1;
        end
        check("bp_first_out", VW'(got), VW'(1));
        @(posedge clk); #1 avail_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_avail_out", VW'(avail_out), VW'(0));
        end
        @(posedge clk); #1 avail_in = 1'b1;
      end
    join
    wait_done("bp");
    chk_lat = 1'b1;

    // Zero items: done next cycle, nothing accepted or emitted
    data_in = 64'h55;
    valid_in = 1'b1;
    cfg(16'd0, 64'h0000_0000_0000_0007, 1'b0);
    @(negedge clk);
    check("zero_done", VW'(done), VW'(1));
    check("zero_avail_out", VW'(avail_out), VW'(0));
    check("zero_valid_out", VW'(valid_out), VW'(0));
    @(negedge clk);
    check("zero_done_pulse", VW'(done), VW'(0));
    check("zero_avail_idle", VW'(avail_out), VW'(0));
    check("zero_valid_idle", VW'(valid_out), VW'(0));
    valid_in = 1'b0;
    @(posedge clk); #1;

    // Mid-run reset after 2 of 5 words accepted
    cfg(16'd5, 64'h0000_0000_0000_0010, 1'b0);
    send(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0011);
    send(64'h0000_0000_0000_0002, 64'h0000_0000_0000_0012);
    valid_in = 1'b0;
    #2 rst = 1'b0;
    sb.delete();
    #1;
    check("mr_avail_out", VW'(avail_out), VW'(0));
    check("mr_valid_out", VW'(valid_out), VW'(0));
    check("mr_done", VW'(done), VW'(0));
    check("mr_data_out", data_out, '0);
    do_reset();
    cfg(16'd2, 64'h0000_0000_0000_0020, 1'b0);
    send(64'h0000_0000_0000_0003, 64'h0000_0000_0000_0023);
    send(64'h0000_0000_0000_0004, 64'h0000_0000_0000_0024);
    valid_in = 1'b0;
    wait_done("mr_fresh");

    // Reconfigure during RUN is ignored
    cfg(16'd3, 64'h0000_0000_0000_0005, 1'b0);
    send(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0006);
    valid_in = 1'b0;
    cfg(16'd1, 64'h0000_0000_0000_0050, 1'b1);
    send(64'h0000_0000_0000_00F0, 64'h0000_0000_0000_00F5);
    send(64'h0000_0000_0000_007E, 64'h0000_0000_0000_007F);
    valid_in = 1'b0;
    wait_done("reconf");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
